// File: rtl/uart_param.sv
// Parametrised full-duplex UART: configurable baud, data width, stop bits, false-start rejection.
// Optional parity bit in both directions when UART_PARITY_EN is defined.
module uart_param #(
    parameter int unsigned CLK_FREQ   = 32000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_send,
    input  logic                 tx_ready,
    output logic                 tx_busy,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned STOP_LEN     = CLKS_PER_BIT * STOP_BITS;
    localparam int unsigned CNT_W        = $clog2(STOP_LEN + 1);
    localparam int unsigned BIT_W        = $clog2(DATA_BITS + 1);
`ifdef UART_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
`endif

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
    } rx_state_t;

    // ---------------- transmitter ----------------
    tx_state_t              tx_state, tx_state_nxt;
    logic [CNT_W-1:0]       tx_cnt, tx_cnt_nxt;
    logic [BIT_W-1:0]       tx_bit, tx_bit_nxt;
    logic [DATA_BITS-1:0]   tx_shreg, tx_shreg_nxt;
    logic                   tx_nxt, tx_busy_nxt;
`ifdef UART_PARITY_EN
    logic                   tx_par, tx_par_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shreg <= tx_shreg_nxt;
            tx       <= tx_nxt;
            tx_busy  <= tx_busy_nxt;
`ifdef UART_PARITY_EN
            tx_par   <= tx_par_nxt;
`endif
        end
    end

    // Line level and busy are computed one cycle ahead so both leave the flops together
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_shreg_nxt = tx_shreg;
        tx_nxt       = tx;
        tx_busy_nxt  = tx_busy;
`ifdef UART_PARITY_EN
        tx_par_nxt   = tx_par;
`endif
        unique case (tx_state)
            TX_IDLE: begin
                tx_nxt      = 1'b1;
                tx_busy_nxt = 1'b0;
                if (tx_ready) begin
                    tx_shreg_nxt = tx_send;
`ifdef UART_PARITY_EN
                    tx_par_nxt   = (^tx_send) ^ PAR_ODD;
`endif
                    tx_cnt_nxt   = '0;
                    tx_bit_nxt   = '0;
                    tx_nxt       = 1'b0;
                    tx_busy_nxt  = 1'b1;
                    tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    tx_cnt_nxt   = '0;
                    tx_nxt       = tx_shreg[0];
                    tx_state_nxt = TX_DATA;
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    tx_cnt_nxt = '0;
                    if (tx_bit == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        tx_nxt       = tx_par;
                        tx_state_nxt = TX_PARITY;
`else
                        tx_nxt       = 1'b1;
                        tx_state_nxt = TX_STOP;
`endif
                    end else begin
                        tx_bit_nxt   = tx_bit + BIT_W'(1);
                        tx_shreg_nxt = tx_shreg >> 1;
                        tx_nxt       = tx_shreg[1];
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_W'(1);
                end
            end
            TX_PARITY: begin
                if (tx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    tx_cnt_nxt   = '0;
                    tx_nxt       = 1'b1;
                    tx_state_nxt = TX_STOP;
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt == CNT_W'(STOP_LEN - 1)) begin
                    tx_cnt_nxt   = '0;
                    tx_busy_nxt  = 1'b0;
                    tx_state_nxt = TX_IDLE;
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_W'(1);
                end
            end
            default: begin
                tx_nxt       = 1'b1;
                tx_busy_nxt  = 1'b0;
                tx_state_nxt = TX_IDLE;
            end
        endcase
    end

    // ---------------- receiver ----------------
    logic rx_meta, rx_s, rx_s_d;

    // Two-flop synchroniser plus one delay stage for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    rx_state_t              rx_state, rx_state_nxt;
    logic [CNT_W-1:0]       rx_cnt, rx_cnt_nxt;
    logic [BIT_W-1:0]       rx_bit, rx_bit_nxt;
    logic [DATA_BITS-1:0]   rx_shreg, rx_shreg_nxt;
    logic [DATA_BITS-1:0]   rx_byte_nxt;
    logic                   ready_nxt, frame_err_nxt;
`ifdef UART_PARITY_EN
    logic                   rx_par, rx_par_nxt;
    logic                   parity_err_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shreg   <= '0;
            rx_byte    <= '0;
            ready      <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par     <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_state   <= rx_state_nxt;
            rx_cnt     <= rx_cnt_nxt;
            rx_bit     <= rx_bit_nxt;
            rx_shreg   <= rx_shreg_nxt;
            rx_byte    <= rx_byte_nxt;
            ready      <= ready_nxt;
            frame_err  <= frame_err_nxt;
`ifdef UART_PARITY_EN
            rx_par     <= rx_par_nxt;
            parity_err <= parity_err_nxt;
`endif
        end
    end

`ifndef UART_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // Start is re-checked at mid-bit; later samples are whole bit periods after that point
    always_comb begin
        rx_state_nxt  = rx_state;
        rx_cnt_nxt    = rx_cnt;
        rx_bit_nxt    = rx_bit;
        rx_shreg_nxt  = rx_shreg;
        rx_byte_nxt   = rx_byte;
        ready_nxt     = 1'b0;
        frame_err_nxt = frame_err;
`ifdef UART_PARITY_EN
        rx_par_nxt     = rx_par;
        parity_err_nxt = parity_err;
`endif
        unique case (rx_state)
            RX_IDLE: begin
                if (rx_s_d && !rx_s) begin
                    rx_cnt_nxt   = '0;
                    rx_bit_nxt   = '0;
                    rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt == CNT_W'(HALF_BIT - 1)) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    rx_cnt_nxt   = '0;
                    rx_shreg_nxt = {rx_s, rx_shreg[DATA_BITS-1:1]};
                    if (rx_bit == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        rx_state_nxt = RX_PARITY;
`else
                        rx_state_nxt = RX_STOP;
`endif
                    end else begin
                        rx_bit_nxt = rx_bit + BIT_W'(1);
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_W'(1);
                end
            end
            RX_PARITY: begin
                if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    rx_cnt_nxt   = '0;
`ifdef UART_PARITY_EN
                    rx_par_nxt   = rx_s;
`endif
                    rx_state_nxt = RX_STOP;
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    rx_cnt_nxt = '0;
                    if (rx_s) begin
                        rx_byte_nxt    = rx_shreg;
                        ready_nxt      = 1'b1;
                        frame_err_nxt  = 1'b0;
`ifdef UART_PARITY_EN
                        parity_err_nxt = rx_par ^ (^rx_shreg) ^ PAR_ODD;
`endif
                        rx_state_nxt   = RX_IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        rx_state_nxt  = RX_BREAK;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_W'(1);
                end
            end
            RX_BREAK: begin
                if (rx_s) begin
                    rx_state_nxt = RX_IDLE;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param with an RX scoreboard and a TX frame sampler.
module tb_uart_param;

    localparam int unsigned CLK_FREQ   = 1000000;
    localparam int unsigned BAUD       = 100000;
    localparam int unsigned CPB        = CLK_FREQ / BAUD;
    localparam int unsigned HALF       = CPB / 2;
    localparam int unsigned STOP_BITS  = 2;
    localparam int unsigned PARITY_ODD = 0;
`ifdef UART_PARITY_EN
    localparam int unsigned DB = 7;
    localparam int unsigned PB = 1;
`else
    localparam int unsigned DB = 8;
    localparam int unsigned PB = 0;
`endif
    localparam int unsigned NBITS = 1 + DB + PB + STOP_BITS;

    typedef struct packed {
        logic [DB-1:0] data;
        logic          perr;
    } rx_exp_t;

    logic          clk = 1'b0;
    logic          rst, rx, rx_drv, loop_en;
    logic          tx, tx_ready, tx_busy, ready, frame_err, parity_err;
    logic [DB-1:0] tx_send, rx_byte;

    rx_exp_t       rx_q[$];
    logic [DB-1:0] tx_q[$];
    rx_exp_t       mon_e;
    logic          prev_ready = 1'b0;
    int            checks   = 0;
    int            failures = 0;
    int unsigned   gap;

    always #5 clk = ~clk;
    assign rx = loop_en ? tx : rx_drv;

    uart_param #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .DATA_BITS (DB),
        .STOP_BITS (STOP_BITS),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .tx        (tx),
        .tx_send   (tx_send),
        .tx_ready  (tx_ready),
        .tx_busy   (tx_busy),
        .rx_byte   (rx_byte),
        .ready     (ready),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic parity(input logic [DB-1:0] d);
        return (^d) ^ 1'(PARITY_ODD);
    endfunction

    // Line image of a frame, index 0 = start bit; unused upper positions read as idle
    function automatic logic [15:0] frame(input logic [DB-1:0] d, input logic p, input logic stop);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < int'(DB); i++) f[1+i] = d[i];
`ifdef UART_PARITY_EN
        f[1+DB] = p;
`endif
        f[1+DB+PB] = stop;
        return f;
    endfunction

    task automatic send_rx(input logic [DB-1:0] d, input logic stop, input logic p);
        logic [15:0] f;
        f = frame(d, p, stop);
        for (int i = 0; i < int'(2 + DB + PB); i++) begin
            @(negedge clk) rx_drv = f[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk) rx_drv = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    // Samples one TX frame mid-bit starting at the current negedge
    task automatic tx_capture(input string tag, input logic inject, input logic chain,
                              input logic [DB-1:0] next_d, output int unsigned w);
        logic [DB-1:0] exp_d;
        logic [15:0]   got;
        int unsigned   busy_len;
        got = '1;
        busy_len = 0;
        w = 0;
        while (tx !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check({tag, " start"}, 32'(tx), 32'd0);
        exp_d = (tx_q.size() > 0) ? tx_q.pop_front() : '0;
        for (int unsigned t = 0; t < NBITS * CPB; t++) begin
            if (tx_busy === 1'b1) busy_len++;
            if (t % CPB == HALF) got[t/CPB] = tx;
            if (inject && t == 3 * CPB) begin
                tx_send  = ~exp_d;
                tx_ready = 1'b1;
            end
            if (inject && t == 3 * CPB + 1) tx_ready = 1'b0;
            @(negedge clk);
        end
        check({tag, " frame"}, 32'(got), 32'(frame(exp_d, parity(exp_d), 1'b1)));
        check({tag, " busy_len"}, busy_len, NBITS * CPB);
        check({tag, " busy_fall"}, 32'(tx_busy), 32'd0);
        if (chain) begin
            tx_send  = next_d;
            tx_ready = 1'b1;
            tx_q.push_back(next_d);
            @(negedge clk) tx_ready = 1'b0;
        end
    endtask

    // RX scoreboard: every ready pulse must match the oldest expected frame
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            check("ready_width", 32'(prev_ready), 32'd0);
            if (rx_q.size() == 0) begin
                check("unexpected_ready", 32'(ready), 32'd0);
            end else begin
                mon_e = rx_q.pop_front();
                check("rx_byte", 32'(rx_byte), 32'(mon_e.data));
                check("rx_parity_err", 32'(parity_err), 32'(mon_e.perr));
                check("rx_frame_err", 32'(frame_err), 32'd0);
            end
        end
        prev_ready = ready;
    end

    initial begin
        int unsigned timeouts;
        int unsigned w;
        rst = 1'b1; tx_ready = 1'b0; tx_send = '0; rx_drv = 1'b1; loop_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst tx", 32'(tx), 32'd1);
        check("rst tx_busy", 32'(tx_busy), 32'd0);
        check("rst rx_byte", 32'(rx_byte), 32'd0);
        check("rst ready", 32'(ready), 32'd0);
        check("rst frame_err", 32'(frame_err), 32'd0);
        check("rst parity_err", 32'(parity_err), 32'd0);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);

        // Two good frames
        rx_q.push_back('{data: DB'(8'hD9), perr: 1'b0});
        send_rx(DB'(8'hD9), 1'b1, parity(DB'(8'hD9)));
        check("t1 frame_err", 32'(frame_err), 32'd0);
        rx_q.push_back('{data: DB'(8'h32), perr: 1'b0});
        send_rx(DB'(8'h32), 1'b1, parity(DB'(8'h32)));
        check("t1 rx_byte", 32'(rx_byte), 32'(DB'(8'h32)));

        // Stop bit low: framing error, data held, then recovery
        send_rx(DB'(8'hA5), 1'b0, parity(DB'(8'hA5)));
        check("t3 frame_err set", 32'(frame_err), 32'd1);
        check("t3 rx_byte held", 32'(rx_byte), 32'(DB'(8'h32)));
        rx_q.push_back('{data: DB'(8'h3C), perr: 1'b0});
        send_rx(DB'(8'h3C), 1'b1, parity(DB'(8'h3C)));
        check("t3 frame_err clr", 32'(frame_err), 32'd0);
        check("t3 rx_byte", 32'(rx_byte), 32'(DB'(8'h3C)));

        // Short low glitch is rejected as a false start
        @(negedge clk) rx_drv = 1'b0;
        repeat (HALF - 2) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("t4 frame_err", 32'(frame_err), 32'd0);
        check("t4 rx_byte", 32'(rx_byte), 32'(DB'(8'h3C)));
        rx_q.push_back('{data: DB'(8'h96), perr: 1'b0});
        send_rx(DB'(8'h96), 1'b1, parity(DB'(8'h96)));
        check("t4 after glitch", 32'(rx_byte), 32'(DB'(8'h96)));

        // Back-to-back TX, with a request during busy that must be dropped
        tx_q.push_back(DB'(8'h55));
        tx_send  = DB'(8'h55);
        tx_ready = 1'b1;
        @(negedge clk) tx_ready = 1'b0;
        tx_capture("tx55", 1'b1, 1'b1, DB'(8'hAA), gap);
        tx_capture("txAA", 1'b0, 1'b0, '0, gap);
        check("tx b2b gap", gap, 32'd0);
        repeat (3 * CPB) @(negedge clk);
        check("tx idle busy", 32'(tx_busy), 32'd0);
        check("tx idle line", 32'(tx), 32'd1);

`ifdef UART_PARITY_EN
        tx_q.push_back(DB'(8'h41));
        tx_send  = DB'(8'h41);
        tx_ready = 1'b1;
        @(negedge clk) tx_ready = 1'b0;
        tx_capture("tx41 par", 1'b0, 1'b0, '0, gap);
        rx_q.push_back('{data: DB'(8'h41), perr: 1'b1});
        send_rx(DB'(8'h41), 1'b1, 1'b1);
        check("t6 parity_err", 32'(parity_err), 32'd1);
        check("t6 rx_byte", 32'(rx_byte), 32'(DB'(8'h41)));
`endif

        // Loopback every code
        loop_en  = 1'b1;
        timeouts = 0;
        for (int b = 0; b < (1 << DB); b++) begin
            @(negedge clk);
            tx_send  = DB'(b);
            tx_ready = 1'b1;
            rx_q.push_back('{data: DB'(b), perr: 1'b0});
            @(negedge clk) tx_ready = 1'b0;
            w = 0;
            while (tx_busy === 1'b1 && w < 4 * NBITS * CPB) begin
                @(negedge clk);
                w++;
            end
            if (w >= 4 * NBITS * CPB) timeouts++;
        end
        repeat (2 * CPB) @(negedge clk);
        check("loop timeouts", timeouts, 32'd0);
        check("loop rx_q empty", 32'(rx_q.size()), 32'd0);

        // Reset in the middle of a frame
        tx_send  = DB'(8'h5A);
        tx_ready = 1'b1;
        @(negedge clk) tx_ready = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst tx", 32'(tx), 32'd1);
        check("midrst tx_busy", 32'(tx_busy), 32'd0);
        check("midrst rx_byte", 32'(rx_byte), 32'd0);
        rst = 1'b0;
        loop_en = 1'b0;
        repeat (2 * NBITS * CPB) @(negedge clk);
        check("midrst idle tx", 32'(tx), 32'd1);
        check("end tx_q empty", 32'(tx_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
